spi_slave_resp: RTL and testbench

// - SPI peripheral-side (slave) responder; the far end of the SPI_0 master link. Receives

---
 rtl/spi_slave_resp.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave_resp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_resp.sv
// SPI slave responder: oversamples SCK/SS/MOSI in the cp2 domain, returns a host byte on MISO.
// Optional receive-overrun flag is built when SPI_SLV_OVR_EN is defined.
module spi_slave_resp #(
    parameter int              DW          = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DW-1:0]   TX_IDLE     = 8'hFF
) (
    input  logic          cp2,
    input  logic          ireset,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          dord,
    input  logic          sck_i,
    input  logic          ss_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_wr,
    output logic          tx_empty,
    output logic [DW-1:0] rx_data,
    input  logic          rx_rd,
    output logic          spif,
    output logic          ovr,
    output logic          busy
);

    localparam int CW = $clog2(DW);

    // state | meaning
    // IDLE  | deselected, MISO released
    // LOAD  | latch tx byte, drive first bit
    // SHIFT | frame in progress
    // DONE  | publish received byte, raise spif
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sck_prev, r_ss_prev;
    logic [DW-1:0]          r_tx_sh, r_rx_sh, r_hold, r_rx_data;
    logic [CW-1:0]          r_cnt;
    logic                   r_miso, r_oe, r_tx_empty, r_spif, r_lead_seen;
    logic                   w_sck, w_ss, w_mosi, w_lead, w_trail, w_ss_fall;
    logic                   w_sample, w_shift, w_last;
    logic [DW-1:0]          w_load_byte;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_sck_sync  <= {SYNC_STAGES{cpol}};
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sck_prev  <= w_sck;
            r_ss_prev   <= w_ss;
        end
    end

    assign w_sck     = r_sck_sync[SYNC_STAGES-1] ^ cpol;
    assign w_ss      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead    = w_sck & ~r_sck_prev;
    assign w_trail   = ~w_sck & r_sck_prev;
    assign w_ss_fall = r_ss_prev & ~w_ss;

    // Shift edges are ignored until the frame's first leading edge: this keeps the
    // cpha=1 first bit in place and drops a stale trailing edge left over from the
    // previous frame when frames run back-to-back in cpha=0.
    assign w_sample = (r_state == SHIFT) & (cpha ? (w_trail & r_lead_seen) : w_lead);
    assign w_shift  = (r_state == SHIFT) & r_lead_seen & (cpha ? w_lead : w_trail);
    assign w_last   = w_sample & (r_cnt == CW'(DW-1));

    assign w_load_byte = r_tx_empty ? TX_IDLE : r_hold;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT: begin
                if (w_ss)        w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = w_ss ? IDLE : LOAD;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SPI_SLV_OVR_EN
    logic r_ovr;
`endif

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_hold      <= '0;
            r_rx_data   <= '0;
            r_cnt       <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_tx_empty  <= 1'b1;
            r_spif      <= 1'b0;
            r_lead_seen <= 1'b0;
`ifdef SPI_SLV_OVR_EN
            r_ovr       <= 1'b0;
`endif
        end else begin
            if (rx_rd) begin
                r_spif <= 1'b0;
`ifdef SPI_SLV_OVR_EN
                r_ovr  <= 1'b0;
`endif
            end
            case (r_state)
                IDLE: r_oe <= 1'b0;
                LOAD: begin
                    r_tx_sh     <= w_load_byte;
                    r_miso      <= dord ? w_load_byte[0] : w_load_byte[DW-1];
                    r_cnt       <= '0;
                    r_oe        <= 1'b1;
                    r_lead_seen <= 1'b0;
                    if (!r_tx_empty) r_tx_empty <= 1'b1;
                end
                SHIFT: begin
                    if (w_ss) begin
                        r_oe <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            r_rx_sh <= dord ? {w_mosi, r_rx_sh[DW-1:1]}
                                            : {r_rx_sh[DW-2:0], w_mosi};
                            r_cnt   <= r_cnt + CW'(1);
                        end
                        if (w_shift) begin
                            if (dord) begin
                                r_tx_sh <= {1'b0, r_tx_sh[DW-1:1]};
                                r_miso  <= r_tx_sh[1];
                            end else begin
                                r_tx_sh <= {r_tx_sh[DW-2:0], 1'b0};
                                r_miso  <= r_tx_sh[DW-2];
                            end
                        end
                        if (w_lead) r_lead_seen <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_ss) r_oe <= 1'b0;
`ifdef SPI_SLV_OVR_EN
                    if (r_spif) r_ovr     <= 1'b1;
                    else        r_rx_data <= r_rx_sh;
`else
                    r_rx_data <= r_rx_sh;
`endif
                    r_spif <= 1'b1;
                end
                default: r_oe <= 1'b0;
            endcase
            // A host write in the LOAD cycle stays pending for the next frame.
            if (tx_wr) begin
                r_hold     <= tx_data;
                r_tx_empty <= 1'b0;
            end
        end
    end

    assign miso_o   = r_miso;
    assign miso_oe  = r_oe & ~w_ss;
    assign tx_empty = r_tx_empty;
    assign rx_data  = r_rx_data;
    assign spif     = r_spif;
    assign busy     = (r_state == SHIFT);
`ifdef SPI_SLV_OVR_EN
    assign ovr      = r_ovr;
`else
    assign ovr      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed bench for spi_slave_resp: a bit-banged SPI master drives frames in all modes
// and checks both directions plus abort, back-to-back, idle-fill and mid-frame reset.
module tb_spi_slave_resp;

    localparam int HALF = 4;

    logic       cp2 = 1'b0;
    logic       ireset = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, dord = 1'b0;
    logic       sck_i = 1'b0, ss_i = 1'b1, mosi_i = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0, rx_rd = 1'b0;
    logic       miso_o, miso_oe, tx_empty, spif, ovr, busy;
    logic [7:0] rx_data;
    logic [7:0] mi, mi2;

    int n_chk = 0;
    int n_pass = 0;

    spi_slave_resp dut (
        .cp2(cp2), .ireset(ireset), .cpol(cpol), .cpha(cpha), .dord(dord),
        .sck_i(sck_i), .ss_i(ss_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_empty(tx_empty), .rx_data(rx_data),
        .rx_rd(rx_rd), .spif(spif), .ovr(ovr), .busy(busy)
    );

    always #5 cp2 = ~cp2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge cp2);
        #1;
    endtask

    task automatic host_tx(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        cyc(1);
        tx_wr   = 1'b0;
    endtask

    task automatic host_rd();
        rx_rd = 1'b1;
        cyc(1);
        rx_rd = 1'b0;
    endtask

    task automatic set_mode(input logic p, input logic h, input logic d);
        cpol  = p;
        cpha  = h;
        dord  = d;
        sck_i = p;
        cyc(8);
    endtask

    task automatic ss_low();
        ss_i = 1'b0;
        cyc(8);
    endtask

    task automatic ss_high();
        cyc(HALF);
        ss_i = 1'b1;
        cyc(10);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rcv);
        logic [7:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = dord ? i : 7 - i;
            if (!cpha) begin
                mosi_i = mo[idx];
                cyc(HALF);
                r[idx] = miso_o;
                sck_i  = ~cpol;
                cyc(HALF);
                sck_i  = cpol;
            end else begin
                sck_i  = ~cpol;
                mosi_i = mo[idx];
                cyc(HALF);
                r[idx] = miso_o;
                sck_i  = cpol;
                cyc(HALF);
            end
        end
        rcv = r;
    endtask

    task automatic frame(input logic [7:0] mo, output logic [7:0] rcv);
        ss_low();
        xfer(mo, 8, rcv);
        ss_high();
    endtask

    logic       cp_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ch_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       do_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] mtx  [6] = '{8'hAA, 8'h55, 8'hC3, 8'h55, 8'hC3, 8'h55};
    logic [7:0] stx  [6] = '{8'h3C, 8'hC3, 8'h55, 8'hC3, 8'h55, 8'h3C};

    initial begin
        cyc(3);
        chk("rst_miso_o",   32'(miso_o),   0);
        chk("rst_miso_oe",  32'(miso_oe),  0);
        chk("rst_tx_empty", 32'(tx_empty), 1);
        chk("rst_rx_data",  32'(rx_data),  0);
        chk("rst_spif",     32'(spif),     0);
        chk("rst_ovr",      32'(ovr),      0);
        chk("rst_busy",     32'(busy),     0);
        ireset = 1'b1;
        cyc(4);

        for (int i = 0; i < 6; i++) begin
            set_mode(cp_t[i], ch_t[i], do_t[i]);
            host_tx(stx[i]);
            chk($sformatf("m%0d_tx_pending", i), 32'(tx_empty), 0);
            frame(mtx[i], mi);
            chk($sformatf("m%0d_rx_data", i),  32'(rx_data),  32'(mtx[i]));
            chk($sformatf("m%0d_spif", i),     32'(spif),     1);
            chk($sformatf("m%0d_master_rx", i), 32'(mi),      32'(stx[i]));
            chk($sformatf("m%0d_tx_empty", i), 32'(tx_empty), 1);
            chk($sformatf("m%0d_oe_ss_hi", i), 32'(miso_oe),  0);
            host_rd();
            chk($sformatf("m%0d_spif_clr", i), 32'(spif),     0);
        end

        // No host byte: idle fill, holding register never fills.
        set_mode(1'b0, 1'b0, 1'b0);
        ss_low();
        chk("idle_empty_start", 32'(tx_empty), 1);
        xfer(8'h5A, 8, mi);
        chk("idle_empty_mid", 32'(tx_empty), 1);
        ss_high();
        chk("idle_master_rx", 32'(mi),       32'hFF);
        chk("idle_rx_data",   32'(rx_data),  32'h5A);
        chk("idle_empty_end", 32'(tx_empty), 1);
        host_rd();

        // Abort after four SCK cycles.
        ss_low();
        xfer(8'hF0, 4, mi);
        chk("abort_busy_mid", 32'(busy),    1);
        chk("abort_oe_mid",   32'(miso_oe), 1);
        cyc(HALF);
        ss_i = 1'b1;
        cyc(10);
        chk("abort_busy",    32'(busy),    0);
        chk("abort_spif",    32'(spif),    0);
        chk("abort_rx_data", 32'(rx_data), 32'h5A);
        frame(8'h81, mi);
        chk("after_abort_rx",   32'(rx_data), 32'h81);
        chk("after_abort_spif", 32'(spif),    1);
        host_rd();

        // Back-to-back frames; second host write wins the holding register.
        host_tx(8'h11);
        host_tx(8'h99);
        ss_low();
        xfer(8'h11, 8, mi);
        xfer(8'h22, 8, mi2);
        ss_high();
        chk("b2b_master_rx1", 32'(mi),   32'h99);
        chk("b2b_master_rx2", 32'(mi2),  32'hFF);
        chk("b2b_spif",       32'(spif), 1);
`ifdef SPI_SLV_OVR_EN
        chk("b2b_ovr",     32'(ovr),     1);
        chk("b2b_rx_data", 32'(rx_data), 32'h11);
`else
        chk("b2b_ovr",     32'(ovr),     0);
        chk("b2b_rx_data", 32'(rx_data), 32'h22);
`endif
        host_rd();
        chk("b2b_spif_clr", 32'(spif), 0);
        chk("b2b_ovr_clr",  32'(ovr),  0);

        // Reset mid-frame, then a clean frame after release.
        host_tx(8'h5A);
        ss_low();
        host_tx(8'h77);
        xfer(8'hC3, 4, mi);
        ireset = 1'b0;
        #1;
        chk("mrst_miso_o",   32'(miso_o),   0);
        chk("mrst_miso_oe",  32'(miso_oe),  0);
        chk("mrst_tx_empty", 32'(tx_empty), 1);
        chk("mrst_rx_data",  32'(rx_data),  0);
        chk("mrst_spif",     32'(spif),     0);
        chk("mrst_ovr",      32'(ovr),      0);
        chk("mrst_busy",     32'(busy),     0);
        ss_i   = 1'b1;
        sck_i  = cpol;
        mosi_i = 1'b0;
        cyc(4);
        ireset = 1'b1;
        cyc(8);
        host_tx(8'hA5);
        frame(8'h3C, mi);
        chk("post_rst_rx_data",   32'(rx_data), 32'h3C);
        chk("post_rst_master_rx", 32'(mi),      32'hA5);
        chk("post_rst_spif",      32'(spif),    1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
